// File: rtl/counter_pkg.sv
// Shared encodings for the programmable interval timer.
package counter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: one tick every P+1 enabled cycles.
module counter_prescaler #(
  parameter int unsigned PWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [PWIDTH-1:0] P,
  output logic              tick_o
);

  logic [PWIDTH-1:0] pcnt_q;

  assign tick_o = enable && !clear && (pcnt_q == P);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else if (clear) begin
      pcnt_q <= '0;
    end else if (enable) begin
      pcnt_q <= tick_o ? '0 : pcnt_q + PWIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_timer.sv
// Programmable interval timer: one-shot or periodic count to N with prescaler,
// pause, abort and restart.
module counter_timer
  import counter_pkg::*;
#(
  parameter int unsigned DWIDTH = 7,
  parameter int unsigned PWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              pause_i,
  input  logic              mode_i,
  input  logic [DWIDTH-1:0] cnt_val_i,
  input  logic [PWIDTH-1:0] presc_i,
  output logic [DWIDTH-1:0] cnt_o,
  output logic              busy_o,
  output logic              done_o
);

  state_e            state_q;
  logic [DWIDTH-1:0] cnt_q;
  logic [DWIDTH-1:0] n_q;
  logic [PWIDTH-1:0] p_q;
  logic              mode_q;
  logic              done_q;

  logic              tick;
  logic              presc_clear;
  logic              presc_en;
  logic [DWIDTH-1:0] cnt_next;

  // Any launch or abort restarts the prescaler phase from zero.
  assign presc_clear = (state_q == ST_IDLE) | start_i | abort_i;
  assign presc_en    = (state_q == ST_RUN) & ~pause_i;
  assign cnt_next    = (cnt_q == n_q) ? DWIDTH'(1) : cnt_q + DWIDTH'(1);

  counter_prescaler #(
    .PWIDTH(PWIDTH)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (presc_clear),
    .enable(presc_en),
    .P     (p_q),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      p_q     <= '0;
      mode_q  <= MODE_ONESHOT;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= ST_IDLE;
      end else if (start_i) begin
        cnt_q <= '0;
        if (cnt_val_i == '0) begin
          // Zero-length interval completes immediately without entering RUN.
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end else begin
          state_q <= ST_RUN;
          n_q     <= cnt_val_i;
          p_q     <= presc_i;
          mode_q  <= mode_i;
        end
      end else if (tick) begin
        cnt_q <= cnt_next;
        if (cnt_next == n_q) begin
          done_q <= 1'b1;
          if (mode_q == MODE_ONESHOT) begin
            state_q <= ST_IDLE;
          end
        end
      end
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (state_q == ST_RUN);
  assign done_o = done_q;

endmodule

// File: doc/counter_timer.md
Name: counter_timer

Overview:
- Parametrised successor to the team's start/done counter.
- Adds a clock-enable prescaler, one-shot or periodic (auto-reload) mode, pause, abort, restart-while-running and a busy flag.
- Sits beside the datapath as a programmable interval timer: a controller launches it with a count value and consumes the `done_o` pulse.

Parameters:
- DWIDTH, 7, width of the count target and of `cnt_o`.
- PWIDTH, 8, width of the prescaler divide value.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start_i  in  1  one-cycle launch strobe; samples `cnt_val_i`, `presc_i` and `mode_i`.
- abort_i  in  1  stop the run immediately, with no `done_o`.
- pause_i  in  1  level; freezes the prescaler and the count while high.
- mode_i  in  1  0 = one-shot, 1 = periodic; sampled only at start.
- cnt_val_i  in  DWIDTH  count target N.
- presc_i  in  PWIDTH  prescaler value P; one tick every P+1 enabled cycles.
- cnt_o  out  DWIDTH  current count.
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle pulse when the count reaches N.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; cnt_o=0, busy_o=0, done_o=0.
  - Prescaler count, latched target, latched P and latched mode all cleared.
  - Reset mid-run abandons the run and produces no done_o.
- States: IDLE and RUN. done_o is a registered pulse, not a state.
- Outputs:
  - busy_o is 1 exactly when state==RUN.
  - done_o defaults to 0 every cycle unless set by the terminal-tick rule.
- IDLE behaviour:
  - cnt_o holds its last value.
  - start_i with N≠0: latch N, P and mode; clear cnt_o and the prescaler count; go to RUN.
  - start_i with N=0: stay in IDLE, cnt_o<=0, done_o pulses in the next cycle.
- Tick generation (RUN with pause_i=0):
  - If the prescaler count equals the latched P: tick, and the prescaler count returns to 0.
  - Otherwise the prescaler count increments.
  - P=0 gives a tick every cycle.
- On a tick:
  - If cnt_o==N, cnt_o<=1 (reload; reachable only in periodic mode).
  - Otherwise cnt_o<=cnt_o+1.
- Terminal tick (the tick where the new cnt_o equals N):
  - done_o<=1.
  - One-shot: go to IDLE, cnt_o holds N.
  - Periodic: stay in RUN.
- Latency with P=0, start sampled at edge k:
  - cnt_o=0 after edge k, 1 after k+1, …, N after k+N.
  - done_o is high for the one cycle after edge k+N.
  - General case: the first tick occurs at edge k+P+1; done_o follows N·(P+1) edges after start.
- Periodic sequence: 0,1..N,1..N,… with done_o on every arrival at N. N=1 gives done_o on every tick.
- pause_i=1 in RUN: prescaler count and cnt_o frozen, no tick, no done_o. pause_i has no effect in IDLE.
- abort_i=1 in RUN: go to IDLE next edge, cnt_o holds, no done_o, busy_o=0. A terminal tick in the same cycle is suppressed.
- start_i in RUN: restart. Relatch all inputs, cnt_o<=0, prescaler count<=0, no done_o for the interrupted run.
- Priority, highest first: rst_n, abort_i, start_i, pause_i, tick. start_i+abort_i together means abort: result is IDLE, no relatch.
- Width rules:
  - All arithmetic is unsigned.
  - cnt_o never exceeds N, so no overflow is possible.
  - N=2^DWIDTH-1 is legal.
  - P=2^PWIDTH-1 is legal, giving a tick every 2^PWIDTH cycles.

Decomposition:
- Shared package counter_pkg holds:
  - state encoding ST_IDLE=1'b0, ST_RUN=1'b1;
  - mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
- One sub-module, counter_prescaler, parametrised by PWIDTH.
  - Inputs: clk, rst_n, clear, enable, P.
  - Output: tick_o.
  - Function: tick when the prescaler count equals P while enable is high; clear forces the count to 0.
- The FSM, count register and done logic live in counter_timer.

Test Plan:
- Reset, then one-shot N=100, P=0 → cnt_o reaches 100 at edge start+100; done_o high for exactly 1 cycle; busy_o falls the same edge; cnt_o holds 100.
- One-shot N=5, P=3 → cnt_o increments every 4 cycles; done_o 20 cycles after start; no extra pulses over a further 50 cycles.
- Periodic N=3, P=0, run 12 cycles → cnt_o 1,2,3,1,2,3,…; done_o at cycles 3,6,9,12; busy_o stays 1; then abort_i → busy_o 0 next cycle, no done_o, cnt_o holds.
- One-shot N=10, P=0, pause_i high cycles 4–8 → cnt_o frozen at 4 during the pause; done_o delayed by 5 cycles, at cycle 15.
- Restart mid-run: N=20 start, at cnt_o=7 start again with N=3 → cnt_o 0,1,2,3; single done_o; start_i+abort_i together → IDLE, no done_o.
- Boundaries: N=0 start → done_o next cycle, busy_o never high; N=127, P=0 → done_o at cycle 127; rst_n low mid-run → all outputs 0 the next cycle, no done_o.
